tick_period_monitor: RTL and testbench
======================================

Name: tick_period_monitor

Overview:
- Receiving end of the periodic single-cycle tick stream produced by the design's clock-delay strobe generators.
- Measures the clk-cycle interval between tick events and reports each measured period.
- Declares lock after a run of in-tolerance periods, and raises a sticky fault on early or late/missing ticks.
- Used to qualify the AES round/trigger strobe before capture logic and side-channel triggers trust it.

Parameters:
- EXPECTED_PERIOD, 11, nominal clk cycles between tick events (generator delay_length + 1).
- TOLERANCE, 0, allowed +/- deviation in cycles.
- LOCK_COUNT, 4, consecutive good periods needed to enter LOCKED (range 1..255).
- CNT_W, 16, width of cycle counter and period output. Must hold EXPECTED_PERIOD + TOLERANCE + 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- enable  in  1  monitor enable. Low forces IDLE.
- tick_in  in  1  tick stream; an event is a rising edge.
- fault_clear  in  1  single-cycle request to leave FAULT.
- period  out  CNT_W  last measured interval in cycles.
- period_valid  out  1  one-cycle strobe when period updates.
- locked  out  1  high while in LOCKED.
- fault  out  1  high while in FAULT (sticky).
- fault_code  out  2  00 none, 01 early, 10 late/missing. Holds its value while fault is high.

Behaviour:
- Reset: all outputs 0, state IDLE, cnt 0, good_run 0, tick_d 0.
- Event detection: event = tick_in & ~tick_d, with tick_d registered each cycle.
  - A tick held high for N cycles is a single event.
- Cycle counter cnt:
  - Cleared to 0 on an event.
  - Otherwise increments, saturating at all-ones.
- Measured period = cnt + 1 at the event.
  - Ticks 11 cycles apart give period = 11.
- period / period_valid:
  - Registered at the event cycle, so visible 1 cycle after the cycle in which tick_in is first sampled high.
  - period_valid is high for exactly one cycle.
  - period holds its value otherwise.
- Good period: EXPECTED_PERIOD - TOLERANCE <= period <= EXPECTED_PERIOD + TOLERANCE.
- State IDLE:
  - Outputs locked = 0, fault = 0, fault_code = 00; cnt and good_run cleared.
  - enable = 1 moves to SYNC.
- State SYNC:
  - Waits for the first event. No period is reported.
  - On the event: cnt cleared, go to TRACK.
- State TRACK:
  - Each event reports a period.
  - Good period: good_run++. When good_run reaches LOCK_COUNT, go to LOCKED (locked high the next cycle).
  - Bad period: good_run = 0, stay in TRACK, no fault.
- State LOCKED, early tick: event with period < EXPECTED_PERIOD - TOLERANCE goes to FAULT with code 01.
- State LOCKED, late tick: no event while cnt + 1 > EXPECTED_PERIOD + TOLERANCE goes to FAULT with code 10.
  - This is a watchdog; it does not wait for the tick.
  - An event whose period is above the window also gives code 10.
- State FAULT:
  - locked = 0, fault = 1, fault_code held. Events are still measured and reported.
  - Stays until fault_clear, then goes to SYNC, clears fault and fault_code, sets good_run = 0.
- Priority:
  - enable low beats everything (go to IDLE).
  - fault_clear beats an event in the same cycle; that event is ignored, and SYNC waits for the next edge.
- enable dropping mid-measurement: immediate IDLE; no period_valid for the partial interval.
- rst mid-operation: everything returns to reset values asynchronously.
- fault_clear outside FAULT: ignored.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SYNC, TRACK, LOCKED, FAULT);
  - fault code constants (FC_NONE, FC_EARLY, FC_LATE);
  - a window-bounds helper computing lo/hi from EXPECTED_PERIOD/TOLERANCE.
- Sub-module tick_edge_detect: registers tick_in and outputs the event pulse; reused by other strobe consumers.
- The counter, comparisons and FSM stay in the top module.

Test Plan:
- Ticks every 11 cycles, defaults -> period_valid with period = 11 from the 2nd edge onward; locked rises 1 cycle after the 5th edge (4 good periods).
- Locked, then one tick arrives 7 cycles after the previous one -> period = 7, fault = 1, fault_code = 01, locked = 0 the next cycle.
- Locked, then ticks stop -> fault_code = 10 exactly 12 cycles after the last edge, with no period_valid.
- In FAULT, pulse fault_clear on the same cycle as a tick edge -> fault = 0 and state SYNC; that edge produces no period_valid, and locking restarts from the following edge.
- TOLERANCE = 1, ticks at 10, 12, 11, 10 cycles -> all good, locked asserts; a 13-cycle gap in TRACK only resets good_run, with fault staying 0.
- tick_in held high for 3 cycles -> one event only. Assert rst mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/tick_period_monitor_pkg.sv
// -----------------------------------------------------------------------------
// tick_period_monitor_pkg
//   Shared definitions for the tick period monitor:
//   - state_e       : monitor FSM states
//   - FC_*          : fault code values reported on fault_code_o
//   - window_t      : inclusive bounds of the "good period" window
//   - window_bounds : derives the window from the nominal period and tolerance
// -----------------------------------------------------------------------------
package tick_period_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_TRACK  = 3'd2,
      ST_LOCKED = 3'd3,
      ST_FAULT  = 3'd4
   } state_e;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_EARLY = 2'b01;
   localparam logic [1:0] FC_LATE  = 2'b10;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
   } window_t;

   // Lower bound clamps at 0 so a tolerance wider than the period cannot wrap.
   function automatic window_t window_bounds(input int unsigned expected,
                                             input int unsigned tolerance);
      window_t w;
      w.lo = (expected > tolerance) ? (expected - tolerance) : 32'd0;
      w.hi = expected + tolerance;
      return w;
   endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// -----------------------------------------------------------------------------
// tick_edge_detect
//   Turns a level tick stream into a single-cycle event on its rising edge.
//   A tick held high for several cycles yields exactly one event.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   tick_i   in   tick stream
//   event_o  out  high in the cycle tick_i is high and was low the cycle before
// -----------------------------------------------------------------------------
module tick_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   output logic event_o
);

   logic tick_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_i;
      end
   end

   assign event_o = tick_i & ~tick_q;

endmodule

// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
//   Measures the clk-cycle interval between tick events, declares lock after
//   LOCK_COUNT consecutive in-window periods, and raises a sticky fault on an
//   early tick or a late/missing tick while locked.
//
// Parameters:
//   EXPECTED_PERIOD  nominal cycles between tick events
//   TOLERANCE        allowed +/- deviation in cycles
//   LOCK_COUNT       consecutive good periods needed to lock (1..255)
//   CNT_W            counter / period width, must hold EXPECTED_PERIOD+TOLERANCE+1
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   enable_i        in   monitor enable, low forces IDLE
//   tick_in_i       in   tick stream, an event is a rising edge
//   fault_clear_i   in   single-cycle request to leave FAULT
//   period_o        out  last measured interval in cycles
//   period_valid_o  out  one-cycle strobe when period_o updates
//   locked_o        out  high while LOCKED
//   fault_o         out  high while FAULT
//   fault_code_o    out  00 none, 01 early, 10 late/missing
// -----------------------------------------------------------------------------
module tick_period_monitor
   import tick_period_monitor_pkg::*;
#(
   parameter int unsigned EXPECTED_PERIOD = 11,
   parameter int unsigned TOLERANCE       = 0,
   parameter int unsigned LOCK_COUNT      = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic             tick_in_i,
   input  logic             fault_clear_i,
   output logic [CNT_W-1:0] period_o,
   output logic             period_valid_o,
   output logic             locked_o,
   output logic             fault_o,
   output logic [1:0]       fault_code_o
);

   localparam window_t        WIN         = window_bounds(EXPECTED_PERIOD, TOLERANCE);
   localparam logic [CNT_W:0] WIN_LO      = (CNT_W+1)'(WIN.lo);
   localparam logic [CNT_W:0] WIN_HI      = (CNT_W+1)'(WIN.hi);
   localparam logic [7:0]     LOCK_TARGET = 8'(LOCK_COUNT);

   // A saturated counter would wrap when extended by one; report all-ones instead.
   function automatic logic [CNT_W-1:0] sat_period(input logic [CNT_W:0] v);
      return v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
   endfunction

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       good_q;
   logic [7:0]       good_inc;
   logic [CNT_W-1:0] period_q;
   logic             pvalid_q;
   logic             locked_q;
   logic             fault_q;
   logic [1:0]       code_q;

   logic             tick_evt;
   logic [CNT_W:0]   meas;
   logic             is_early;
   logic             is_late;
   logic             is_good;

   tick_edge_detect u_edge (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick_in_i),
      .event_o (tick_evt)
   );

   // Period ending in this cycle; one bit wider so the compare never wraps.
   assign meas     = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign is_early = (meas < WIN_LO);
   assign is_late  = (meas > WIN_HI);
   assign is_good  = ~is_early & ~is_late;
   assign good_inc = good_q + 8'd1;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable_i || (state_q == ST_IDLE)) begin
         cnt_d = '0;
      end else if (tick_evt) begin
         cnt_d = '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         good_q   <= '0;
         period_q <= '0;
         pvalid_q <= 1'b0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= FC_NONE;
      end else begin
         cnt_q    <= cnt_d;
         pvalid_q <= 1'b0;
         if (!enable_i) begin
            // Partial interval is discarded: no period strobe on the way out.
            state_q  <= ST_IDLE;
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  state_q <= ST_SYNC;
                  good_q  <= '0;
               end
               ST_SYNC: begin
                  // First edge only establishes the phase reference.
                  if (tick_evt) begin
                     state_q <= ST_TRACK;
                  end
               end
               ST_TRACK: begin
                  if (tick_evt) begin
                     period_q <= sat_period(meas);
                     pvalid_q <= 1'b1;
                     if (is_good) begin
                        good_q <= good_inc;
                        if (good_inc == LOCK_TARGET) begin
                           state_q  <= ST_LOCKED;
                           locked_q <= 1'b1;
                        end
                     end else begin
                        good_q <= '0;
                     end
                  end
               end
               ST_LOCKED: begin
                  if (tick_evt) begin
                     period_q <= sat_period(meas);
                     pvalid_q <= 1'b1;
                     if (is_early || is_late) begin
                        state_q  <= ST_FAULT;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b1;
                        code_q   <= is_early ? FC_EARLY : FC_LATE;
                     end
                  end else if (is_late) begin
                     // Watchdog: the window closed without a tick.
                     state_q  <= ST_FAULT;
                     locked_q <= 1'b0;
                     fault_q  <= 1'b1;
                     code_q   <= FC_LATE;
                  end
               end
               ST_FAULT: begin
                  // Clear wins over a coincident edge; SYNC then waits for a fresh edge.
                  if (fault_clear_i) begin
                     state_q <= ST_SYNC;
                     fault_q <= 1'b0;
                     code_q  <= FC_NONE;
                     good_q  <= '0;
                  end else if (tick_evt) begin
                     period_q <= sat_period(meas);
                     pvalid_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign period_o       = period_q;
   assign period_valid_o = pvalid_q;
   assign locked_o       = locked_q;
   assign fault_o        = fault_q;
   assign fault_code_o   = code_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
`timescale 1ns/1ps
module tb_tick_period_monitor;

   localparam int EP    = 11;
   localparam int TOL0  = 0;
   localparam int TOL1  = 1;
   localparam int LOCKN = 4;
   localparam int W     = 16;

   localparam int M_IDLE   = 0;
   localparam int M_SYNC   = 1;
   localparam int M_TRACK  = 2;
   localparam int M_LOCKED = 3;
   localparam int M_FAULT  = 4;

   logic clk = 1'b0;
   logic rst, enable, tick_in, fault_clear;

   logic [W-1:0] d_period [2];
   logic         d_pv     [2];
   logic         d_locked [2];
   logic         d_fault  [2];
   logic [1:0]   d_code   [2];

   always #5 clk = ~clk;

   tick_period_monitor #(
      .EXPECTED_PERIOD(EP), .TOLERANCE(TOL0), .LOCK_COUNT(LOCKN), .CNT_W(W)
   ) dut0 (
      .clk(clk), .rst(rst), .enable_i(enable), .tick_in_i(tick_in),
      .fault_clear_i(fault_clear), .period_o(d_period[0]),
      .period_valid_o(d_pv[0]), .locked_o(d_locked[0]),
      .fault_o(d_fault[0]), .fault_code_o(d_code[0])
   );

   tick_period_monitor #(
      .EXPECTED_PERIOD(EP), .TOLERANCE(TOL1), .LOCK_COUNT(LOCKN), .CNT_W(W)
   ) dut1 (
      .clk(clk), .rst(rst), .enable_i(enable), .tick_in_i(tick_in),
      .fault_clear_i(fault_clear), .period_o(d_period[1]),
      .period_valid_o(d_pv[1]), .locked_o(d_locked[1]),
      .fault_o(d_fault[1]), .fault_code_o(d_code[1])
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (time-stamp based) ----------------
   int           now = 0;
   bit           m_tkp = 1'b0;
   int           m_mode [2];
   int           m_last [2];
   int           m_good [2];
   logic [W-1:0] e_period [2];
   logic         e_pv     [2];
   logic         e_locked [2];
   logic         e_fault  [2];
   logic [1:0]   e_code   [2];

   task automatic m_report(input int i, input int p);
      e_period[i] = W'(p);
      e_pv[i]     = 1'b1;
      m_last[i]   = now;
   endtask

   task automatic m_fault(input int i, input logic [1:0] code);
      m_mode[i]   = M_FAULT;
      e_locked[i] = 1'b0;
      e_fault[i]  = 1'b1;
      e_code[i]   = code;
   endtask

   task automatic model_step();
      bit evt;
      evt   = tick_in && !m_tkp;
      m_tkp = rst ? 1'b0 : tick_in;
      now++;
      for (int i = 0; i < 2; i++) begin
         int  tol;
         int  p;
         bit  good;
         tol  = (i == 0) ? TOL0 : TOL1;
         p    = now - m_last[i];          // cycles since the last counted edge
         good = (p >= EP - tol) && (p <= EP + tol);
         e_pv[i] = 1'b0;
         if (rst) begin
            m_mode[i] = M_IDLE; m_good[i] = 0; m_last[i] = 0;
            e_period[i] = '0; e_locked[i] = 1'b0; e_fault[i] = 1'b0; e_code[i] = 2'b00;
         end else if (!enable) begin
            m_mode[i] = M_IDLE; m_good[i] = 0;
            e_locked[i] = 1'b0; e_fault[i] = 1'b0; e_code[i] = 2'b00;
         end else begin
            case (m_mode[i])
               M_IDLE: m_mode[i] = M_SYNC;
               M_SYNC: if (evt) begin m_last[i] = now; m_mode[i] = M_TRACK; end
               M_TRACK: if (evt) begin
                  m_report(i, p);
                  if (good) begin
                     m_good[i]++;
                     if (m_good[i] == LOCKN) begin m_mode[i] = M_LOCKED; e_locked[i] = 1'b1; end
                  end else begin
                     m_good[i] = 0;
                  end
               end
               M_LOCKED: begin
                  if (evt) begin
                     m_report(i, p);
                     if (p < EP - tol)      m_fault(i, 2'b01);
                     else if (p > EP + tol) m_fault(i, 2'b10);
                  end else if (p > EP + tol) begin
                     m_fault(i, 2'b10);
                  end
               end
               M_FAULT: begin
                  if (fault_clear) begin
                     m_mode[i] = M_SYNC; m_good[i] = 0; e_fault[i] = 1'b0; e_code[i] = 2'b00;
                  end else if (evt) begin
                     m_report(i, p);
                  end
               end
               default: m_mode[i] = M_IDLE;
            endcase
         end
      end
   endtask

   // Model advances on the clock edge, DUT is compared 1 ns later every cycle.
   always @(posedge clk) begin
      model_step();
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("dut%0d.period", i),       32'(d_period[i]), 32'(e_period[i]));
         check($sformatf("dut%0d.period_valid", i), 32'(d_pv[i]),     32'(e_pv[i]));
         check($sformatf("dut%0d.locked", i),       32'(d_locked[i]), 32'(e_locked[i]));
         check($sformatf("dut%0d.fault", i),        32'(d_fault[i]),  32'(e_fault[i]));
         check($sformatf("dut%0d.fault_code", i),   32'(d_code[i]),   32'(e_code[i]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle tick; returns at the negedge where the edge's result is visible.
   task automatic pulse();
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; tick_in = 1'b0; fault_clear = 1'b0;
      idle(3);
      check("reset.period",     32'(d_period[0]), 0);
      check("reset.valid",      32'(d_pv[0]),     0);
      check("reset.locked",     32'(d_locked[0]), 0);
      check("reset.fault",      32'(d_fault[0]),  0);
      check("reset.fault_code", 32'(d_code[0]),   0);
      rst = 1'b0;
      idle(1);
      enable = 1'b1;
      idle(2);

      // Nominal ticks every 11 cycles: lock after the 5th edge.
      pulse();
      for (int k = 1; k <= 4; k++) begin
         idle(10); pulse();
         if (k == 1) begin
            check("nominal.first_period", 32'(d_period[0]), 11);
            check("nominal.first_valid",  32'(d_pv[0]),     1);
         end
         if (k == 3) check("nominal.not_locked_yet", 32'(d_locked[0]), 0);
      end
      check("nominal.locked",      32'(d_locked[0]), 1);
      check("nominal.locked_tol1", 32'(d_locked[1]), 1);
      idle(10); pulse();
      check("nominal.stays_locked", 32'(d_locked[0]), 1);

      // Early tick 7 cycles after the previous one.
      idle(6); pulse();
      check("early.period",      32'(d_period[0]), 7);
      check("early.valid",       32'(d_pv[0]),     1);
      check("early.fault",       32'(d_fault[0]),  1);
      check("early.code",        32'(d_code[0]),   1);
      check("early.locked",      32'(d_locked[0]), 0);
      check("early.code_tol1",   32'(d_code[1]),   1);

      // fault_clear coincident with an edge: edge ignored, relock from next edges.
      idle(4);
      fault_clear = 1'b1;
      pulse();
      fault_clear = 1'b0;
      check("clear.fault",      32'(d_fault[0]), 0);
      check("clear.code",       32'(d_code[0]),  0);
      check("clear.no_valid",   32'(d_pv[0]),    0);
      idle(10); pulse();
      check("clear.sync_edge_silent", 32'(d_pv[0]), 0);
      for (int k = 1; k <= 4; k++) begin
         idle(10); pulse();
         if (k == 1) begin
            check("relock.first_period", 32'(d_period[0]), 11);
            check("relock.first_valid",  32'(d_pv[0]),     1);
         end
      end
      check("relock.locked", 32'(d_locked[0]), 1);

      // Ticks stop: watchdog fires 12 cycles after the last edge.
      idle(11);
      check("late.before_window", 32'(d_fault[0]), 0);
      idle(1);
      check("late.fault",    32'(d_fault[0]),  1);
      check("late.code",     32'(d_code[0]),   2);
      check("late.no_valid", 32'(d_pv[0]),     0);
      check("late.locked",   32'(d_locked[0]), 0);
      idle(3);
      fault_clear = 1'b1; idle(1); fault_clear = 1'b0;
      check("late.cleared",      32'(d_fault[0]), 0);
      check("late.cleared_tol1", 32'(d_fault[1]), 0);

      // TOLERANCE=1 instance: 13-cycle gap in TRACK only resets the run.
      idle(2); pulse();
      idle(9);  pulse();
      idle(11); pulse();
      idle(12); pulse();
      check("tol.gap13_period", 32'(d_period[1]), 13);
      check("tol.gap13_fault",  32'(d_fault[1]),  0);
      check("tol.gap13_locked", 32'(d_locked[1]), 0);
      check("tol.tol0_no_fault", 32'(d_fault[0]), 0);
      idle(9);  pulse();
      idle(11); pulse();
      idle(10); pulse();
      check("tol.three_good_unlocked", 32'(d_locked[1]), 0);
      idle(9);  pulse();
      check("tol.locked",        32'(d_locked[1]), 1);
      check("tol.last_period",   32'(d_period[1]), 10);
      check("tol.tol0_unlocked", 32'(d_locked[0]), 0);
      check("tol.tol0_fault",    32'(d_fault[0]),  0);

      // Tick held high for 3 cycles counts as one event.
      idle(10);
      tick_in = 1'b1;
      idle(1);
      check("held.valid",  32'(d_pv[1]),     1);
      check("held.period", 32'(d_period[1]), 11);
      idle(1);
      check("held.single_event", 32'(d_pv[1]), 0);
      idle(1);
      tick_in = 1'b0;
      idle(8); pulse();
      check("held.next_period", 32'(d_period[1]), 11);
      check("held.still_locked", 32'(d_locked[1]), 1);

      // enable drop with an edge in the same cycle: IDLE, nothing reported.
      idle(5);
      enable = 1'b0;
      pulse();
      check("disable.no_valid", 32'(d_pv[1]),     0);
      check("disable.unlocked", 32'(d_locked[1]), 0);
      idle(3);
      enable = 1'b1;
      idle(2);

      // Asynchronous reset mid-count.
      pulse();
      idle(10); pulse();
      check("prerst.period", 32'(d_period[0]), 11);
      idle(4);
      rst = 1'b1;
      #1;
      check("rst.period",      32'(d_period[0]), 0);
      check("rst.valid",       32'(d_pv[0]),     0);
      check("rst.locked_tol1", 32'(d_locked[1]), 0);
      check("rst.fault",       32'(d_fault[0]),  0);
      check("rst.code",        32'(d_code[0]),   0);
      @(negedge clk);
      rst = 1'b0;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
